// File: rtl/cpu_ce_switch_if.sv
// Handshake bundle between the top level and the CPU clock-enable switch.
// The switch drives the enables and status; the requester drives mode and wait.
interface cpu_ce_switch_if #(
   parameter int MW = 1
);
   logic [MW-1:0] mode_req;
   logic          wait_req;
   logic          ce_p;
   logic          ce_n;
   logic [MW-1:0] mode_cur;
   logic          switching;
   logic          ce_psg;

   modport master (
      output mode_req, wait_req,
      input  ce_p, ce_n, mode_cur, switching, ce_psg
   );

   modport slave (
      input  mode_req, wait_req,
      output ce_p, ce_n, mode_cur, switching, ce_psg
   );
endinterface

// File: rtl/cpu_ce_switch.sv
// CPU clock-enable generator: paired ce_p/ce_n at a selectable period, glitch-free mode
// changes through a silent gap, per-mode contention wait, and a free-running PSG enable.
module cpu_ce_switch #(
   parameter int                       NMODES    = 2,
   parameter int                       DIV_W     = 6,
   parameter logic [NMODES*DIV_W-1:0]  PERIODS   = {6'd54, 6'd16},
   parameter logic [NMODES-1:0]        WAIT_MASK = 2'b01,
   parameter int                       GAP_CYC   = 64,
   parameter int                       PSG_DIV   = 12
) (
   input logic              clk_sys,
   input logic              reset,
   cpu_ce_switch_if.slave   bus
);

   localparam int MW = (NMODES > 1) ? $clog2(NMODES) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int PW = $clog2(PSG_DIV);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STOP,
      ST_GAP
   } state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  phase_q, phase_d;
   logic              hold_q, hold_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [MW-1:0]     mode_q, mode_d;
   logic              ce_p_q, ce_p_d;
   logic              ce_n_q, ce_n_d;
   logic              switching_q, switching_d;
   logic [PW-1:0]     psg_q, psg_d;
   logic              ce_psg_q, ce_psg_d;

   logic [DIV_W-1:0]  period;
   logic [DIV_W-1:0]  phase_last;
   logic [DIV_W-1:0]  phase_half;
   logic              req_valid;
   logic              req_change;
   logic              hold_now;

   always_comb begin
      period     = PERIODS[32'(mode_q) * DIV_W +: DIV_W];
      phase_last = period - 1'b1;
      phase_half = period >> 1;
      req_valid  = 32'(bus.mode_req) < NMODES;
      req_change = req_valid && (bus.mode_req != mode_q);
      // Wait is sampled only on the period boundary so a period is either fully run or fully frozen.
      hold_now   = (phase_q == '0) ? (bus.wait_req & WAIT_MASK[mode_q]) : hold_q;
   end

   // NOTE: every next-state value gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      hold_d   = hold_q;
      gap_d    = gap_q;
      mode_d   = mode_q;
      ce_p_d   = 1'b0;
      ce_n_d   = 1'b0;
      psg_d    = (psg_q == PW'(PSG_DIV - 1)) ? '0 : psg_q + 1'b1;
      ce_psg_d = (psg_q == '0);

      unique case (state_q)
         ST_RUN: begin
            hold_d  = hold_now;
            phase_d = (phase_q == phase_last) ? '0 : phase_q + 1'b1;
            ce_p_d  = (phase_q == '0) && !hold_now;
            ce_n_d  = (phase_q == phase_half) && !hold_q;
            // A switch is only taken at the end of a full CPU period.
            if ((phase_q == phase_last) && req_change) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            gap_d   = GW'(GAP_CYC - 1);
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_RUN;
               phase_d = '0;
               if (req_valid) begin
                  mode_d = bus.mode_req;
               end
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
            phase_d = '0;
         end
      endcase

      switching_d = (state_d != ST_RUN);
   end

   // NOTE: state is updated with non-blocking assignments so every register samples the
   // values from before this edge, independent of statement order.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= ST_RUN;
         phase_q     <= '0;
         hold_q      <= 1'b0;
         gap_q       <= '0;
         mode_q      <= req_valid ? bus.mode_req : '0;
         ce_p_q      <= 1'b0;
         ce_n_q      <= 1'b0;
         switching_q <= 1'b0;
         psg_q       <= '0;
         ce_psg_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         hold_q      <= hold_d;
         gap_q       <= gap_d;
         mode_q      <= mode_d;
         ce_p_q      <= ce_p_d;
         ce_n_q      <= ce_n_d;
         switching_q <= switching_d;
         psg_q       <= psg_d;
         ce_psg_q    <= ce_psg_d;
      end
   end

   assign bus.ce_p      = ce_p_q;
   assign bus.ce_n      = ce_n_q;
   assign bus.mode_cur  = mode_q;
   assign bus.switching = switching_q;
   assign bus.ce_psg    = ce_psg_q;

endmodule

// File: tb/tb_cpu_ce_switch.sv
// Directed bench for cpu_ce_switch: a segment table for mode-0 cadence and wait gating,
// hand sequences for mode changes, gap abort by reset, and an invalid-mode instance.
module tb_cpu_ce_switch;

   logic clk = 1'b0;
   logic reset;
   logic reset3;

   always #5 clk = ~clk;

   cpu_ce_switch_if #(.MW(1)) bus ();
   cpu_ce_switch_if #(.MW(2)) bus3 ();

   cpu_ce_switch u_dut (
      .clk_sys (clk),
      .reset   (reset),
      .bus     (bus)
   );

   cpu_ce_switch #(
      .NMODES    (3),
      .DIV_W     (6),
      .PERIODS   ({6'd20, 6'd54, 6'd16}),
      .WAIT_MASK (3'b001),
      .GAP_CYC   (64),
      .PSG_DIV   (12)
   ) u_dut3 (
      .clk_sys (clk),
      .reset   (reset3),
      .bus     (bus3)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return bus.ce_p;
         1:       return bus.ce_n;
         2:       return bus.switching;
         3:       return !bus.switching;
         4:       return bus3.switching;
         5:       return bus3.ce_p;
         default: return 1'b0;
      endcase
   endfunction

   // Steps until the selected signal is seen high; k is the number of steps, -1 on timeout.
   task automatic wait_for(input int sel, input int budget, output int k);
      k = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (sig(sel) === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   // Independent monitors: pulse exclusivity/spacing and PSG cadence.
   int mcyc = 0;
   int sp_viol = 0, psg_viol = 0, psg_seen = 0;
   int last_pulse = 0, last_psg = 0;
   bit pulse_armed = 0, psg_armed = 0;

   always @(negedge clk) begin
      mcyc++;
      if (bus.ce_p === 1'b1 && bus.ce_n === 1'b1) sp_viol++;
      if (bus.ce_p === 1'b1 || bus.ce_n === 1'b1) begin
         if (pulse_armed && (mcyc - last_pulse) < 8) sp_viol++;
         last_pulse  = mcyc;
         pulse_armed = 1;
      end
      if (bus.ce_psg === 1'b1) begin
         if (psg_armed && (mcyc - last_psg) != 12) psg_viol++;
         last_psg  = mcyc;
         psg_armed = 1;
         psg_seen++;
      end else if (psg_armed && (mcyc - last_psg) > 12) begin
         psg_viol++;
         psg_armed = 0;
      end
      if (reset === 1'b1) begin
         pulse_armed = 0;
         psg_armed   = 0;
      end
   end

   typedef struct {
      logic       wait_req;
      logic [0:0] mode_req;
      int         ncyc;
      int         exp_p;
      int         exp_n;
      int         exp_sw;
      int         exp_mode;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int k, p, n, s;

      // Segments run back to back from reset release, each starting at a known phase.
      vecs[0] = '{1'b0, 1'b0, 48, 3, 3, 0, 0};  // free run P=16
      vecs[1] = '{1'b1, 1'b0, 32, 0, 0, 0, 0};  // wait held over two period starts
      vecs[2] = '{1'b0, 1'b0, 16, 1, 1, 0, 0};  // resumes immediately
      vecs[3] = '{1'b0, 1'b0,  5, 1, 0, 0, 0};  // phases 0..4
      vecs[4] = '{1'b1, 1'b0,  1, 0, 0, 0, 0};  // wait pulse at phase 5 only
      vecs[5] = '{1'b0, 1'b0, 10, 0, 1, 0, 0};  // phases 6..15, ce_n not lost

      reset         = 1'b1;
      reset3        = 1'b1;
      bus.mode_req  = 1'b0;
      bus.wait_req  = 1'b0;
      bus3.mode_req = 2'd3;
      bus3.wait_req = 1'b0;
      repeat (3) step();
      check("rst_ce_p",      bus.ce_p,      0);
      check("rst_ce_n",      bus.ce_n,      0);
      check("rst_ce_psg",    bus.ce_psg,    0);
      check("rst_switching", bus.switching, 0);
      check("rst_mode_cur",  bus.mode_cur,  0);
      check("rst3_mode_cur_invalid_req", bus3.mode_cur, 0);
      reset = 1'b0;

      foreach (vecs[r]) begin
         bus.wait_req = vecs[r].wait_req;
         bus.mode_req = vecs[r].mode_req;
         p = 0; n = 0; s = 0;
         for (int i = 0; i < vecs[r].ncyc; i++) begin
            step();
            if (bus.ce_p === 1'b1) p++;
            if (bus.ce_n === 1'b1) n++;
            if (bus.switching === 1'b1) s++;
         end
         check($sformatf("vec%0d_ce_p_count", r), p, vecs[r].exp_p);
         check($sformatf("vec%0d_ce_n_count", r), n, vecs[r].exp_n);
         check($sformatf("vec%0d_switching",  r), s, vecs[r].exp_sw);
         check($sformatf("vec%0d_mode_cur",   r), bus.mode_cur, vecs[r].exp_mode);
      end

      // Mode 0 -> 1 requested at phase 3: period completes, then 1+64 silent cycles.
      bus.wait_req = 1'b0;
      repeat (3) step();
      bus.mode_req = 1'b1;
      wait_for(2, 40, k);
      check("sw01_rise_delay", k, 13);
      s = 1;
      wait_for(3, 100, k);
      check("sw01_high_cycles", k, 65);
      check("sw01_mode_cur", bus.mode_cur, 1);
      wait_for(0, 10, k);
      check("sw01_first_ce_p", k, 1);

      // Mode 1 ignores wait: ce_n 27 after ce_p, ce_p every 54.
      bus.wait_req = 1'b1;
      wait_for(1, 100, k);
      check("m1_wait_ce_n_offset", k, 27);
      wait_for(0, 100, k);
      check("m1_wait_ce_p_offset", k, 27);
      wait_for(0, 100, k);
      check("m1_wait_period", k, 54);

      // Request 0, then revert to 1 mid-gap: gap is not restarted, mode stays 1.
      bus.wait_req = 1'b0;
      bus.mode_req = 1'b0;
      wait_for(2, 100, k);
      check("revert_rise_delay", k, 53);
      repeat (10) step();
      bus.mode_req = 1'b1;
      wait_for(3, 100, k);
      check("revert_gap_rest", k, 55);
      check("revert_mode_cur", bus.mode_cur, 1);
      wait_for(0, 10, k);
      check("revert_first_ce_p", k, 1);
      wait_for(0, 100, k);
      check("revert_period", k, 54);
      s = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (bus.switching === 1'b1) s++;
      end
      check("revert_no_second_gap", s, 0);

      // Reset in the middle of a gap aborts it on the next cycle.
      bus.mode_req = 1'b0;
      wait_for(2, 100, k);
      check("rgap_entered", k > 0, 1);
      repeat (5) step();
      reset = 1'b1;
      step();
      check("rgap_switching", bus.switching, 0);
      check("rgap_ce_p",      bus.ce_p,      0);
      check("rgap_ce_psg",    bus.ce_psg,    0);
      check("rgap_mode_cur",  bus.mode_cur,  0);
      reset = 1'b0;
      wait_for(0, 10, k);
      check("rgap_first_ce_p", k, 1);
      wait_for(1, 40, k);
      check("rgap_ce_n_offset", k, 8);
      wait_for(0, 40, k);
      check("rgap_ce_p_offset", k, 8);

      // Three-mode instance: mode 3 is out of range and must be ignored.
      reset3 = 1'b0;
      p = 0; s = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus3.ce_p === 1'b1) p++;
         if (bus3.switching === 1'b1) s++;
      end
      check("inv_no_gap", s, 0);
      check("inv_ce_p_count", p, 7);
      check("inv_mode_cur", bus3.mode_cur, 0);
      bus3.mode_req = 2'd2;
      wait_for(4, 40, k);
      check("m2_rise_delay", k, 12);
      wait_for(5, 200, k);
      check("m2_first_ce_p", k, 66);
      wait_for(5, 100, k);
      check("m2_period", k, 20);
      check("m2_mode_cur", bus3.mode_cur, 2);

      step();
      check("pulse_spacing_viol", sp_viol, 0);
      check("psg_cadence_viol", psg_viol, 0);
      check("psg_alive", psg_seen >= 40, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
